// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU issue/writeback controller.
//   DATA_W   operand width
//   OP_W     ALU select width
//   REG_AW   register-file address width
//   RES_W    ALU result width (operand width plus carry)
//   state_e  controller states
package alu_pkg;

    localparam int unsigned DATA_W   = 4;
    localparam int unsigned OP_W     = 4;
    localparam int unsigned REG_AW   = 2;
    localparam int unsigned RES_W    = DATA_W + 1;
    localparam int unsigned NUM_REGS = 1 << REG_AW;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/alu_regfile.sv
// Small operand register file: two asynchronous read ports, one synchronous
// write port, asynchronous reset of all entries to zero.
//   clk, rst               clock, async active-high reset
//   we_i/waddr_i/wdata_i   write port (takes effect on rising edge)
//   raddr_a_i/rdata_a_o    read port A (combinational)
//   raddr_b_i/rdata_b_o    read port B (combinational)
module alu_regfile
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W_P = alu_pkg::DATA_W,
    parameter int unsigned REG_AW_P = alu_pkg::REG_AW
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we_i,
    input  logic [REG_AW_P-1:0] waddr_i,
    input  logic [DATA_W_P-1:0] wdata_i,
    input  logic [REG_AW_P-1:0] raddr_a_i,
    output logic [DATA_W_P-1:0] rdata_a_o,
    input  logic [REG_AW_P-1:0] raddr_b_i,
    output logic [DATA_W_P-1:0] rdata_b_o
);

    localparam int unsigned DEPTH = 1 << REG_AW_P;

    logic [DATA_W_P-1:0] mem_q [DEPTH];

    // Storage with write port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read ports see current contents, so a read in the accept cycle
    // never observes a write that has not yet landed.
    assign rdata_a_o = mem_q[raddr_a_i];
    assign rdata_b_o = mem_q[raddr_b_i];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue and writeback controller placed in front of a combinational ALU.
// Accepts one command at a time, reads operands from the register file (or
// an immediate), drives the ALU for one cycle, writes the result back and
// presents it on a valid/ready response channel.
//   clk, rst                      clock, async active-high reset
//   cmd_valid/cmd_ready           command handshake (ready only in IDLE)
//   cmd_op/rd/ra/rb/imm_en/imm/load  command fields
//   alu_s/alu_a/alu_b             registered drive into the ALU
//   alu_result                    ALU result (DATA_W+1 bits)
//   rsp_valid/rsp_ready/rsp_data  response channel
//   carry                         sticky carry from the last ALU op
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W = alu_pkg::DATA_W,
    parameter int unsigned OP_W   = alu_pkg::OP_W,
    parameter int unsigned REG_AW = alu_pkg::REG_AW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [OP_W-1:0]   cmd_op,
    input  logic [REG_AW-1:0] cmd_rd,
    input  logic [REG_AW-1:0] cmd_ra,
    input  logic [REG_AW-1:0] cmd_rb,
    input  logic              cmd_imm_en,
    input  logic [DATA_W-1:0] cmd_imm,
    input  logic              cmd_load,
    output logic [OP_W-1:0]   alu_s,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W:0]   alu_result,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W:0]   rsp_data,
    output logic              carry
);

    state_e              state_q;
    logic [OP_W-1:0]     op_q;
    logic [DATA_W-1:0]   a_q;
    logic [DATA_W-1:0]   b_q;
    logic [DATA_W-1:0]   imm_q;
    logic [REG_AW-1:0]   rd_q;
    logic                load_q;
    logic                cmd_ready_q;
    logic                rsp_valid_q;
    logic [DATA_W:0]     rsp_data_q;
    logic                carry_q;

    logic [DATA_W-1:0]   rf_rdata_a;
    logic [DATA_W-1:0]   rf_rdata_b;
    logic                rf_we_c;
    logic [DATA_W-1:0]   rf_wdata_c;

    // Writeback lands on the edge that ends EXEC; loads bypass the ALU.
    assign rf_we_c    = (state_q == EXEC);
    assign rf_wdata_c = load_q ? imm_q : alu_result[DATA_W-1:0];

    alu_regfile #(
        .DATA_W_P (DATA_W),
        .REG_AW_P (REG_AW)
    ) u_rf (
        .clk       (clk),
        .rst       (rst),
        .we_i      (rf_we_c),
        .waddr_i   (rd_q),
        .wdata_i   (rf_wdata_c),
        .raddr_a_i (cmd_ra),
        .rdata_a_o (rf_rdata_a),
        .raddr_b_i (cmd_rb),
        .rdata_b_o (rf_rdata_b)
    );

    // Controller FSM with registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            imm_q       <= '0;
            rd_q        <= '0;
            load_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            carry_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        op_q        <= cmd_op;
                        a_q         <= rf_rdata_a;
                        b_q         <= cmd_imm_en ? cmd_imm : rf_rdata_b;
                        imm_q       <= cmd_imm;
                        rd_q        <= cmd_rd;
                        load_q      <= cmd_load;
                        cmd_ready_q <= 1'b0;
                        state_q     <= EXEC;
                    end
                end
                EXEC: begin
                    if (load_q) begin
                        rsp_data_q <= {1'b0, imm_q};
                    end else begin
                        rsp_data_q <= alu_result;
                        carry_q    <= alu_result[DATA_W];
                    end
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: begin
                    // cmd_ready rises only after IDLE is reached: no same-cycle accept.
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    rsp_valid_q <= 1'b0;
                    cmd_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign carry     = carry_q;
    assign alu_s     = op_q;
    assign alu_a     = a_q;
    assign alu_b     = b_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: an environment ALU (reference function or stub),
// a register-file/carry reference model, and one task per scenario.
module tb_alu_issue_ctrl;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_op;
    logic [1:0] cmd_rd;
    logic [1:0] cmd_ra;
    logic [1:0] cmd_rb;
    logic       cmd_imm_en;
    logic [3:0] cmd_imm;
    logic       cmd_load;
    logic [3:0] alu_s;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [4:0] alu_result;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [4:0] rsp_data;
    logic       carry;

    int         vectors     = 0;
    int         miscompares = 0;

    // Environment ALU: 0 = reference ALU, 1 = constant stub, 2 = A+B stub
    int         alu_mode    = 0;
    logic [4:0] stub_val    = 5'h00;

    logic [3:0] model_rf [4];
    logic       model_carry;

    logic [3:0] o_s, o_a, o_b, e_a, e_b;
    logic [4:0] o_rsp, e_rsp;
    logic       o_rv, o_rdy;

    alu_issue_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_rd     (cmd_rd),
        .cmd_ra     (cmd_ra),
        .cmd_rb     (cmd_rb),
        .cmd_imm_en (cmd_imm_en),
        .cmd_imm    (cmd_imm),
        .cmd_load   (cmd_load),
        .alu_s      (alu_s),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .carry      (carry)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [4:0] ref_alu(input logic [3:0] s, input logic [3:0] a, input logic [3:0] b);
        logic [4:0] ea, eb;
        ea = {1'b0, a};
        eb = {1'b0, b};
        case (s)
            4'd0:  return ea + eb;
            4'd1:  return ea - eb;
            4'd2:  return {1'b0, a & b};
            4'd3:  return {1'b0, a | b};
            4'd4:  return {1'b0, a ^ b};
            4'd5:  return {1'b0, ~a};
            4'd6:  return {a, 1'b0};
            4'd7:  return {1'b0, a >> 1};
            4'd8:  return ea + 5'd1;
            4'd9:  return ea - 5'd1;
            4'd10: return ea + eb + 5'd1;
            4'd11: return {1'b0, ~(a & b)};
            4'd12: return {1'b0, b};
            4'd13: return {1'b0, a};
            4'd14: return ea + ea + eb;
            default: return 5'h1F;
        endcase
    endfunction

    function automatic logic [4:0] env_alu(input int mode, input logic [4:0] sv,
                                           input logic [3:0] s, input logic [3:0] a, input logic [3:0] b);
        if (mode == 1) return sv;
        if (mode == 2) return {1'b0, a} + {1'b0, b};
        return ref_alu(s, a, b);
    endfunction

    assign alu_result = env_alu(alu_mode, stub_val, alu_s, alu_a, alu_b);

    task automatic model_reset();
        for (int i = 0; i < 4; i++) model_rf[i] = 4'h0;
        model_carry = 1'b0;
    endtask

    // Architectural effect of one command on the reference model.
    task automatic model_cmd(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] ra,
                             input logic [1:0] rb, input logic imm_en, input logic [3:0] imm,
                             input logic load, output logic [3:0] ea, output logic [3:0] eb,
                             output logic [4:0] er);
        ea = model_rf[ra];
        eb = imm_en ? imm : model_rf[rb];
        if (load) begin
            er = {1'b0, imm};
            model_rf[rd] = imm;
        end else begin
            er = env_alu(alu_mode, stub_val, op, ea, eb);
            model_rf[rd] = er[3:0];
            model_carry  = er[4];
        end
    endtask

    // Drive one command through accept/EXEC/RESP and report what was seen.
    task automatic run_cmd(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] ra,
                           input logic [1:0] rb, input logic imm_en, input logic [3:0] imm,
                           input logic load, output logic [3:0] ex_s, output logic [3:0] ex_a,
                           output logic [3:0] ex_b, output logic [4:0] rsp, output logic rv,
                           output logic rdy_after);
        int guard = 0;
        @(negedge clk);
        while (cmd_ready !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20) begin
            vectors++; miscompares++;
            $display("FAIL cmd_ready_timeout: cmd_ready=%b required 1", cmd_ready);
        end
        cmd_valid = 1'b1; cmd_op = op; cmd_rd = rd; cmd_ra = ra; cmd_rb = rb;
        cmd_imm_en = imm_en; cmd_imm = imm; cmd_load = load;
        @(negedge clk);
        // Scramble fields after accept: they must be ignored from here on.
        cmd_valid = 1'b0;
        cmd_op = 4'($urandom); cmd_imm = 4'($urandom);
        cmd_ra = 2'($urandom); cmd_rb = 2'($urandom); cmd_rd = 2'($urandom);
        ex_s = alu_s; ex_a = alu_a; ex_b = alu_b;
        @(negedge clk);
        rv = rsp_valid; rsp = rsp_data;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        rdy_after = cmd_ready;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
        vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        vectors++; if (rsp_data !== 5'h00) begin miscompares++; $display("FAIL reset_rsp_data: got %h want 00", rsp_data); end
        vectors++; if ({alu_s, alu_a, alu_b} !== 12'h000) begin miscompares++; $display("FAIL reset_alu_drive: got %h/%h/%h want 0/0/0", alu_s, alu_a, alu_b); end
        vectors++; if (carry !== 1'b0) begin miscompares++; $display("FAIL reset_carry: got %b want 0", carry); end
        for (int i = 0; i < 4; i++) begin
            vectors++; if (dut.u_rf.mem_q[i] !== 4'h0) begin miscompares++; $display("FAIL reset_reg%0d: got %h want 0", i, dut.u_rf.mem_q[i]); end
        end
    endtask

    task automatic test_load_then_op();
        alu_mode = 0;
        model_cmd(4'h0, 2'd0, 2'd0, 2'd0, 1'b0, 4'h3, 1'b1, e_a, e_b, e_rsp);
        run_cmd(4'h0, 2'd0, 2'd0, 2'd0, 1'b0, 4'h3, 1'b1, o_s, o_a, o_b, o_rsp, o_rv, o_rdy);
        vectors++; if (o_rsp !== 5'h03 || o_rv !== 1'b1) begin miscompares++; $display("FAIL load_r0: got rsp=%h valid=%b want 03/1", o_rsp, o_rv); end
        model_cmd(4'h0, 2'd1, 2'd0, 2'd0, 1'b0, 4'h4, 1'b1, e_a, e_b, e_rsp);
        run_cmd(4'h0, 2'd1, 2'd0, 2'd0, 1'b0, 4'h4, 1'b1, o_s, o_a, o_b, o_rsp, o_rv, o_rdy);
        vectors++; if (o_rsp !== 5'h04 || o_rdy !== 1'b1) begin miscompares++; $display("FAIL load_r1: got rsp=%h ready_after=%b want 04/1", o_rsp, o_rdy); end
        alu_mode = 1; stub_val = 5'h07;
        model_cmd(4'h0, 2'd2, 2'd0, 2'd1, 1'b0, 4'h0, 1'b0, e_a, e_b, e_rsp);
        run_cmd(4'h0, 2'd2, 2'd0, 2'd1, 1'b0, 4'h0, 1'b0, o_s, o_a, o_b, o_rsp, o_rv, o_rdy);
        vectors++; if (o_a !== 4'h3 || o_b !== 4'h4 || o_s !== 4'h0) begin miscompares++; $display("FAIL op_operands: got s=%h a=%h b=%h want 0/3/4", o_s, o_a, o_b); end
        vectors++; if (o_rsp !== 5'h07 || o_rv !== 1'b1) begin miscompares++; $display("FAIL op_rsp: got %h valid=%b want 07/1", o_rsp, o_rv); end
        vectors++; if (dut.u_rf.mem_q[2] !== 4'h7) begin miscompares++; $display("FAIL op_r2: got %h want 7", dut.u_rf.mem_q[2]); end
        vectors++; if (carry !== 1'b0) begin miscompares++; $display("FAIL op_carry: got %b want 0", carry); end
    endtask

    task automatic test_op_sweep();
        alu_mode = 0;
        for (int s = 0; s < 16; s++) begin
            logic [1:0] rb;
            rb = 2'($urandom);
            model_cmd(4'(s), 2'd3, 2'd0, rb, 1'b1, 4'h4, 1'b0, e_a, e_b, e_rsp);
            run_cmd(4'(s), 2'd3, 2'd0, rb, 1'b1, 4'h4, 1'b0, o_s, o_a, o_b, o_rsp, o_rv, o_rdy);
            vectors++; if (o_s !== 4'(s) || o_a !== 4'h3 || o_b !== 4'h4) begin miscompares++; $display("FAIL sweep_drive op%0d: got s=%h a=%h b=%h want %h/3/4", s, o_s, o_a, o_b, 4'(s)); end
            vectors++; if (o_rsp !== e_rsp) begin miscompares++; $display("FAIL sweep_rsp op%0d: got %h want %h", s, o_rsp, e_rsp); end
            vectors++; if (carry !== model_carry) begin miscompares++; $display("FAIL sweep_carry op%0d: got %b want %b", s, carry, model_carry); end
        end
    endtask

    task automatic test_carry();
        alu_mode = 1; stub_val = 5'h13;
        model_cmd(4'h5, 2'd3, 2'd0, 2'd0, 1'b0, 4'h0, 1'b0, e_a, e_b, e_rsp);
        run_cmd(4'h5, 2'd3, 2'd0, 2'd0, 1'b0, 4'h0, 1'b0, o_s, o_a, o_b, o_rsp, o_rv, o_rdy);
        vectors++; if (o_rsp !== 5'h13) begin miscompares++; $display("FAIL carry_rsp: got %h want 13", o_rsp); end
        vectors++; if (dut.u_rf.mem_q[3] !== 4'h3) begin miscompares++; $display("FAIL carry_rd: got %h want 3", dut.u_rf.mem_q[3]); end
        vectors++; if (carry !== 1'b1) begin miscompares++; $display("FAIL carry_set: got %b want 1", carry); end
        model_cmd(4'h0, 2'd0, 2'd0, 2'd0, 1'b0, 4'h6, 1'b1, e_a, e_b, e_rsp);
        run_cmd(4'h0, 2'd0, 2'd0, 2'd0, 1'b0, 4'h6, 1'b1, o_s, o_a, o_b, o_rsp, o_rv, o_rdy);
        vectors++; if (carry !== 1'b1 || o_rsp !== 5'h06) begin miscompares++; $display("FAIL carry_after_load: got carry=%b rsp=%h want 1/06", carry, o_rsp); end
    endtask

    task automatic test_self_overwrite();
        alu_mode = 2;
        model_cmd(4'h0, 2'd1, 2'd0, 2'd0, 1'b0, 4'h5, 1'b1, e_a, e_b, e_rsp);
        run_cmd(4'h0, 2'd1, 2'd0, 2'd0, 1'b0, 4'h5, 1'b1, o_s, o_a, o_b, o_rsp, o_rv, o_rdy);
        model_cmd(4'h9, 2'd1, 2'd1, 2'd1, 1'b0, 4'h0, 1'b0, e_a, e_b, e_rsp);
        run_cmd(4'h9, 2'd1, 2'd1, 2'd1, 1'b0, 4'h0, 1'b0, o_s, o_a, o_b, o_rsp, o_rv, o_rdy);
        vectors++; if (o_a !== 4'h5 || o_b !== 4'h5) begin miscompares++; $display("FAIL self_operands: got a=%h b=%h want 5/5", o_a, o_b); end
        vectors++; if (o_rsp !== 5'h0A) begin miscompares++; $display("FAIL self_rsp: got %h want 0A", o_rsp); end
        vectors++; if (dut.u_rf.mem_q[1] !== 4'hA) begin miscompares++; $display("FAIL self_r1: got %h want A", dut.u_rf.mem_q[1]); end
    endtask

    task automatic test_backpressure();
        logic [4:0] exp1, exp2;
        int guard = 0;
        alu_mode = 0;
        model_cmd(4'h0, 2'd2, 2'd0, 2'd1, 1'b0, 4'h0, 1'b0, e_a, e_b, exp1);
        @(negedge clk);
        while (cmd_ready !== 1'b1 && guard < 20) begin @(negedge clk); guard++; end
        if (guard >= 20) begin vectors++; miscompares++; $display("FAIL bp_ready_timeout: cmd_ready=%b required 1", cmd_ready); end
        cmd_valid = 1'b1; cmd_op = 4'h0; cmd_rd = 2'd2; cmd_ra = 2'd0; cmd_rb = 2'd1;
        cmd_imm_en = 1'b0; cmd_imm = 4'h0; cmd_load = 1'b0;
        @(negedge clk);
        // Second command held valid from EXEC through the stalled RESP.
        cmd_op = 4'hB; cmd_rd = 2'd3; cmd_imm = 4'hC; cmd_load = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (rsp_valid !== 1'b1 || cmd_ready !== 1'b0 || rsp_data !== exp1) begin
                miscompares++;
                $display("FAIL bp_hold cyc%0d: got valid=%b ready=%b data=%h want 1/0/%h", i, rsp_valid, cmd_ready, rsp_data, exp1);
            end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        vectors++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || alu_s !== 4'h0) begin miscompares++; $display("FAIL bp_idle: got ready=%b valid=%b s=%h want 1/0/0", cmd_ready, rsp_valid, alu_s); end
        model_cmd(4'hB, 2'd3, 2'd0, 2'd1, 1'b0, 4'hC, 1'b1, e_a, e_b, exp2);
        @(negedge clk);
        cmd_valid = 1'b0;
        vectors++; if (cmd_ready !== 1'b0 || alu_s !== 4'hB) begin miscompares++; $display("FAIL bp_second_accept: got ready=%b s=%h want 0/B", cmd_ready, alu_s); end
        @(negedge clk);
        vectors++; if (rsp_valid !== 1'b1 || rsp_data !== exp2) begin miscompares++; $display("FAIL bp_second_rsp: got valid=%b data=%h want 1/%h", rsp_valid, rsp_data, exp2); end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_random();
        alu_mode = 0;
        for (int n = 0; n < 40; n++) begin
            logic [3:0] op, imm;
            logic [1:0] rd, ra, rb;
            logic       imm_en, load;
            op = 4'($urandom); imm = 4'($urandom);
            rd = 2'($urandom); ra = 2'($urandom); rb = 2'($urandom);
            imm_en = 1'($urandom); load = ($urandom_range(0, 3) == 0);
            model_cmd(op, rd, ra, rb, imm_en, imm, load, e_a, e_b, e_rsp);
            run_cmd(op, rd, ra, rb, imm_en, imm, load, o_s, o_a, o_b, o_rsp, o_rv, o_rdy);
            if (!load) begin
                vectors++; if (o_s !== op || o_a !== e_a || o_b !== e_b) begin miscompares++; $display("FAIL rand_drive #%0d: got %h/%h/%h want %h/%h/%h", n, o_s, o_a, o_b, op, e_a, e_b); end
            end
            vectors++; if (o_rsp !== e_rsp || o_rv !== 1'b1 || o_rdy !== 1'b1) begin miscompares++; $display("FAIL rand_rsp #%0d: got %h valid=%b rdy=%b want %h/1/1", n, o_rsp, o_rv, o_rdy, e_rsp); end
            vectors++; if (carry !== model_carry) begin miscompares++; $display("FAIL rand_carry #%0d: got %b want %b", n, carry, model_carry); end
        end
        for (int i = 0; i < 4; i++) begin
            vectors++; if (dut.u_rf.mem_q[i] !== model_rf[i]) begin miscompares++; $display("FAIL rand_reg%0d: got %h want %h", i, dut.u_rf.mem_q[i], model_rf[i]); end
        end
    endtask

    task automatic test_reset_mid_exec();
        int guard = 0;
        alu_mode = 1; stub_val = 5'h1F;
        @(negedge clk);
        while (cmd_ready !== 1'b1 && guard < 20) begin @(negedge clk); guard++; end
        if (guard >= 20) begin vectors++; miscompares++; $display("FAIL rst_ready_timeout: cmd_ready=%b required 1", cmd_ready); end
        cmd_valid = 1'b1; cmd_op = 4'h7; cmd_rd = 2'd0; cmd_ra = 2'd1; cmd_rb = 2'd2;
        cmd_imm_en = 1'b1; cmd_imm = 4'h9; cmd_load = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        rst = 1'b1;
        #1;
        model_reset();
        vectors++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || carry !== 1'b0) begin miscompares++; $display("FAIL rst_exec_ctrl: got valid=%b ready=%b carry=%b want 0/1/0", rsp_valid, cmd_ready, carry); end
        vectors++; if ({alu_s, alu_a, alu_b} !== 12'h000 || rsp_data !== 5'h00) begin miscompares++; $display("FAIL rst_exec_outs: got %h/%h/%h data=%h want 0", alu_s, alu_a, alu_b, rsp_data); end
        for (int i = 0; i < 4; i++) begin
            vectors++; if (dut.u_rf.mem_q[i] !== 4'h0) begin miscompares++; $display("FAIL rst_exec_reg%0d: got %h want 0", i, dut.u_rf.mem_q[i]); end
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++; if (rsp_valid !== 1'b0 || dut.u_rf.mem_q[0] !== 4'h0) begin miscompares++; $display("FAIL rst_no_rsp cyc%0d: got valid=%b r0=%h want 0/0", i, rsp_valid, dut.u_rf.mem_q[0]); end
        end
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_rd = '0; cmd_ra = '0; cmd_rb = '0;
        cmd_imm_en = 1'b0; cmd_imm = '0; cmd_load = 1'b0; rsp_ready = 1'b0;
        test_reset();
        test_load_then_op();
        test_op_sweep();
        test_carry();
        test_self_overwrite();
        test_backpressure();
        test_random();
        test_reset_mid_exec();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete, vectors=%0d", vectors);
        $fatal(1);
    end

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Sequential issue and writeback controller that sits directly upstream of the combinational `ALU` and feeds its `S`, `A` and `B` inputs. It accepts one command at a time over a valid/ready handshake and reads operands from a 4-entry x 4-bit register file, or takes B from an immediate. It drives the ALU, captures the 5-bit `result`, writes it back, and returns it on a valid/ready response channel.

## Interface
Parameters:
- `DATA_W`, 4, operand width (ALU `A`/`B`)
- `OP_W`, 4, ALU select width (ALU `S`)
- `REG_AW`, 2, register-file address width (4 entries)

Ports:
- `clk`  in  1  single clock, all state on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `cmd_valid`  in  1  command present
- `cmd_ready`  out  1  controller can accept (high only in IDLE)
- `cmd_op`  in  OP_W  ALU select
- `cmd_rd`  in  REG_AW  destination register
- `cmd_ra`  in  REG_AW  source A register
- `cmd_rb`  in  REG_AW  source B register
- `cmd_imm_en`  in  1  B taken from `cmd_imm` instead of `reg[cmd_rb]`
- `cmd_imm`  in  DATA_W  immediate
- `cmd_load`  in  1  write `cmd_imm` to `rd`; bypasses the ALU
- `alu_s`  out  OP_W  to ALU `S`
- `alu_a`  out  DATA_W  to ALU `A`
- `alu_b`  out  DATA_W  to ALU `B`
- `alu_result`  in  DATA_W+1  from ALU `result`
- `rsp_valid`  out  1  response present
- `rsp_ready`  in  1  consumer accepts response
- `rsp_data`  out  DATA_W+1  captured result
- `carry`  out  1  sticky copy of `result[4]` from the last ALU op

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE**
  - `cmd_ready`=1.
  - Accept when `cmd_valid` is high. On accept, latch op, rd, load flag and operands; then go to EXEC.
  - Operand A = `reg[ra]`. Operand B = `cmd_imm_en ? cmd_imm : reg[rb]`.
  - Both operands are read from register-file contents in the accept cycle.
- **EXEC** (exactly one cycle)
  - `alu_s`/`alu_a`/`alu_b` are driven from the latched values and the ALU evaluates combinationally.
  - At the end of the cycle, `rsp_data` <= `alu_result`, `reg[rd]` <= `alu_result[3:0]`, `carry` <= `alu_result[4]`. Then go to RESP.
  - Load command: `rsp_data` <= {1'b0, imm}, `reg[rd]` <= imm, `carry` unchanged.
- **RESP**
  - `rsp_valid`=1, with `rsp_data` stable until `rsp_ready`.
  - On `rsp_ready`, go to IDLE. `cmd_ready` rises in the following cycle; there is no same-cycle accept.
- `alu_s`/`alu_a`/`alu_b` hold their latched values until the next accept, so the ALU output stays stable for observation.
- Width: the low 4 bits of the result are written back and bit 4 goes only to `carry` and `rsp_data[4]`. No truncation or extension beyond that.
- All 16 `cmd_op` values are passed through unmodified; the controller does not decode the op.
- `rd` may equal `ra`/`rb`: the read happens at accept and the write at the end of EXEC, so there is no hazard.

## Timing
- Reset values: state=IDLE, `cmd_ready`=1, `rsp_valid`=0, `rsp_data`=0, `alu_s`/`alu_a`/`alu_b`=0, `carry`=0, all registers 0.
- Latency: accept in cycle N, EXEC in N+1, `rsp_valid` high in N+2.
- Throughput: one command per 3 cycles minimum when `rsp_ready` is held high.
- Backpressure: `rsp_ready` low holds RESP indefinitely. `cmd_ready` stays 0, and `cmd_valid` and command fields are ignored.
- `rst` asserted mid-operation (EXEC or RESP):
  - Immediate return to the reset values and IDLE.
  - A pending writeback is discarded and no response is produced.
- `cmd_valid` changing while `cmd_ready`=0 has no effect.

## Structure
- Shared package `alu_pkg`:
  - `DATA_W`, `OP_W`, `REG_AW` constants.
  - State enum `{IDLE, EXEC, RESP}`.
  - Result width `DATA_W+1`.
- Sub-module `alu_regfile`:
  - 4 x DATA_W storage.
  - Two asynchronous read ports and one synchronous write port with enable.
  - Asynchronous reset to 0.
- The ALU is not instantiated inside this block. The top level connects `alu_s`/`alu_a`/`alu_b`/`alu_result` to `ALU`.

## Test plan
- **Reset:** assert `rst` mid-EXEC -> `rsp_valid`=0, `cmd_ready`=1, `carry`=0 and all registers 0 in the same cycle, with no writeback.
- **Load then op:**
  - load r0=3, then load r1=4 -> each returns `rsp_data`=5'h03 / 5'h04.
  - Then op `S`=0, ra=0, rb=1, rd=2 -> `alu_a`=3 and `alu_b`=4 in EXEC.
  - With an ALU stub returning 5'h07: `rsp_data`=5'h07 at N+2, r2=7, `carry`=0.
- **Op sweep:** issue `S`=0..15 with A=3, B=4 (via immediate) -> `alu_s` equals each value in its EXEC cycle, and `rsp_data` matches the reference ALU model for every op.
- **Carry:** ALU stub returns 5'h13 -> `rd`=4'h3, `carry`=1. A following load leaves `carry`=1.
- **Backpressure:** hold `rsp_ready`=0 for 5 cycles while `cmd_valid`=1 -> `rsp_data` stable, `cmd_ready`=0, and the second command is accepted only after `rsp_ready` and a return to IDLE.
- **Self-overwrite:** r1=5, op with ra=rb=rd=1 and stub = A+B -> `alu_a`=`alu_b`=5, r1=4'hA, `rsp_data`=5'h0A.
